// File: rtl/hamming_pkg.sv
// Shared helpers for the extended-Hamming (SECDED) code family: layout math
// used by both the decoder and the future parametrised encoder.
package hamming_pkg;

  localparam int unsigned MAX_DATA_W = 57;
  localparam int unsigned MAX_POS    = 128;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_DOUBLE
  } err_kind_e;

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned par_w(input int unsigned data_w);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < 8; p++) begin
      if (result == 0 && ((32'd1 << p) >= data_w + p + 1)) begin
        result = p;
      end
    end
    return result;
  endfunction

  // Hamming position of data bit k: the k-th non-power-of-two position >= 3.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned cnt;
    int unsigned result;
    cnt    = 0;
    result = 0;
    for (int unsigned p = 3; p < MAX_POS; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k && result == 0) begin
          result = p;
        end
        cnt++;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Stream bundle for the SECDED decoder: codeword in, corrected word plus flags out.
interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  localparam int unsigned CODE_W = DATA_W + par_w(DATA_W) + 1
) ();

  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_single;
  logic              out_double;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_code,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_single,
    input  out_double,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_code,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_single,
    output out_double,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/overall-parity generator for an extended-Hamming codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  localparam int unsigned PAR_W  = par_w(DATA_W),
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  syndrome,
  output logic              parity
);

  always_comb begin
    syndrome = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (code[i]) begin
        syndrome ^= PAR_W'(i);
      end
    end
  end

  assign parity = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage streaming SECDED decoder with saturating single/double error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = par_w(DATA_W),
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hamming_secded_decoder_if.slave  bus,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         cnt_single,
  output logic [CNT_W-1:0]         cnt_double
);

  logic [PAR_W-1:0]  syn;
  logic              par;

  logic              s1_valid;
  logic [CODE_W-1:1] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic              s2_load;
  logic              fire;
  err_kind_e         kind;
  logic [CODE_W-1:1] fixed;
  logic [DATA_W-1:0] fixed_data;

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code     (bus.in_code),
    .syndrome (syn),
    .parity   (par)
  );

  // Stage 2 accepts whenever it is empty or its word leaves this cycle;
  // stage 1 follows the same rule one step upstream.
  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign fire         = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code <= bus.in_code[CODE_W-1:1];
        s1_syn  <= syn;
        s1_par  <= par;
      end
    end
  end

  // Syndromes beyond the last codeword position cannot come from one flip.
  always_comb begin
    kind = ERR_NONE;
    if (s1_par) begin
      kind = (32'(s1_syn) < CODE_W) ? ERR_SINGLE : ERR_DOUBLE;
    end else if (s1_syn != '0) begin
      kind = ERR_DOUBLE;
    end
  end

  always_comb begin
    fixed = s1_code;
    if (kind == ERR_SINGLE) begin
      for (int unsigned i = 1; i < CODE_W; i++) begin
        if (s1_syn == PAR_W'(i)) begin
          fixed[i] = ~s1_code[i];
        end
      end
    end
  end

  always_comb begin
    fixed_data = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      fixed_data[k] = fixed[data_pos(k)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_single <= 1'b0;
      bus.out_double <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data   <= fixed_data;
        bus.out_single <= (kind == ERR_SINGLE);
        bus.out_double <= (kind == ERR_DOUBLE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clr_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (fire && bus.out_single && cnt_single != '1) begin
        cnt_single <= cnt_single + CNT_W'(1);
      end
      if (fire && bus.out_double && cnt_double != '1) begin
        cnt_double <= cnt_double + CNT_W'(1);
      end
    end
  end

  flags_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.out_single && bus.out_double));

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder at DATA_W=4 (CNT_W=2) and DATA_W=32.
module tb_hamming_secded_decoder;

  typedef struct packed {
    logic [63:0] data;
    logic        single;
    logic        dbl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr4;
  logic        clr32;
  logic [1:0]  cs4;
  logic [1:0]  cd4;
  logic [15:0] cs32;
  logic [15:0] cd32;
  logic [7:0]  syn_code;
  logic [2:0]  syn_s;
  logic        syn_p;
  logic        done;

  exp_t        q4[$];
  exp_t        q32[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder_if #(.DATA_W(4))  bus4 ();
  hamming_secded_decoder_if #(.DATA_W(32)) bus32 ();

  hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus4),
    .clr_cnt    (clr4),
    .cnt_single (cs4),
    .cnt_double (cd4)
  );

  hamming_secded_decoder #(.DATA_W(32), .CNT_W(16)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus32),
    .clr_cnt    (clr32),
    .cnt_single (cs32),
    .cnt_double (cd32)
  );

  hamming_syndrome #(.DATA_W(4)) u_syn (
    .code     (syn_code),
    .syndrome (syn_s),
    .parity   (syn_p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic int unsigned m_codew(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < dw + p + 1) p++;
    return dw + p + 1;
  endfunction

  function automatic logic [63:0] m_encode(input int unsigned dw, input logic [63:0] data);
    logic [63:0] c;
    logic        pb;
    int unsigned cw;
    int unsigned k;
    c  = '0;
    cw = m_codew(dw);
    k  = 0;
    for (int unsigned pos = 1; pos < cw; pos++) begin
      if (!m_pow2(pos)) begin
        c[pos] = data[k];
        k++;
      end
    end
    for (int unsigned b = 1; b < cw; b = b << 1) begin
      pb = 1'b0;
      for (int unsigned pos = 1; pos < cw; pos++) begin
        if ((pos & b) != 0) pb ^= c[pos];
      end
      c[b] = pb;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [63:0] m_extract(input int unsigned dw, input logic [63:0] c);
    logic [63:0] d;
    int unsigned cw;
    int unsigned k;
    d  = '0;
    cw = m_codew(dw);
    k  = 0;
    for (int unsigned pos = 1; pos < cw; pos++) begin
      if (!m_pow2(pos)) begin
        d[k] = c[pos];
        k++;
      end
    end
    return d;
  endfunction

  // Expected result from how many bits were planted in a clean codeword.
  function automatic exp_t m_expect(input int unsigned dw, input logic [63:0] data,
                                    input logic [63:0] c, input int unsigned nflips);
    exp_t e;
    if (nflips == 0)      e = '{data: data, single: 1'b0, dbl: 1'b0};
    else if (nflips == 1) e = '{data: data, single: 1'b1, dbl: 1'b0};
    else                  e = '{data: m_extract(dw, c), single: 1'b0, dbl: 1'b1};
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic send(input int unsigned inst, input logic [63:0] code, input exp_t e);
    logic rdy;
    logic acc;
    acc = 1'b0;
    if (inst == 0) begin
      bus4.in_code  = code[7:0];
      bus4.in_valid = 1'b1;
    end else begin
      bus32.in_code  = code[38:0];
      bus32.in_valid = 1'b1;
    end
    for (int unsigned w = 0; w < 64 && !acc; w++) begin
      @(negedge clk);
      rdy = (inst == 0) ? bus4.in_ready : bus32.in_ready;
      @(posedge clk);
      if (rdy) acc = 1'b1;
    end
    if (acc) begin
      if (inst == 0) q4.push_back(e);
      else q32.push_back(e);
    end else begin
      check("accept_timeout", 64'(acc), 64'd1);
    end
    #1;
    if (inst == 0) bus4.in_valid = 1'b0;
    else bus32.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned inst);
    int unsigned n;
    int unsigned sz;
    n  = 0;
    sz = (inst == 0) ? q4.size() : q32.size();
    while (sz != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      sz = (inst == 0) ? q4.size() : q32.size();
    end
    check("drain", 64'(sz), 64'd0);
  endtask

  // Occupancy equals scoreboard depth, so in_ready may drop only at depth 2 with no out_ready.
  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready4", 64'(bus4.in_ready), 64'(!(q4.size() == 2 && !bus4.out_ready)));
      if (q4.size() == 0) begin
        check("idle_valid4", 64'(bus4.out_valid), 64'd0);
      end else if (bus4.out_valid) begin
        check("data4", 64'(bus4.out_data), q4[0].data);
        check("single4", 64'(bus4.out_single), 64'(q4[0].single));
        check("double4", 64'(bus4.out_double), 64'(q4[0].dbl));
        if (bus4.out_ready) void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready32", 64'(bus32.in_ready), 64'(!(q32.size() == 2 && !bus32.out_ready)));
      if (q32.size() == 0) begin
        check("idle_valid32", 64'(bus32.out_valid), 64'd0);
      end else if (bus32.out_valid) begin
        check("data32", 64'(bus32.out_data), q32[0].data);
        check("single32", 64'(bus32.out_single), 64'(q32[0].single));
        check("double32", 64'(bus32.out_double), 64'(q32[0].dbl));
        if (bus32.out_ready) void'(q32.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] c;
    logic [63:0] base;
    int unsigned nf;
    int unsigned p1;
    int unsigned p2;

    reset_n        = 1'b0;
    clr4           = 1'b0;
    clr32          = 1'b0;
    done           = 1'b0;
    syn_code       = '0;
    bus4.in_valid  = 1'b0;
    bus4.in_code   = '0;
    bus4.out_ready = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.in_code   = '0;
    bus32.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid4", 64'(bus4.out_valid), 64'd0);
    check("rst_data4", 64'(bus4.out_data), 64'd0);
    check("rst_single4", 64'(bus4.out_single), 64'd0);
    check("rst_double4", 64'(bus4.out_double), 64'd0);
    check("rst_ready4", 64'(bus4.in_ready), 64'd1);
    check("rst_cnt4", 64'({cs4, cd4}), 64'd0);
    check("rst_valid32", 64'(bus32.out_valid), 64'd0);
    check("rst_cnt32", 64'({cs32, cd32}), 64'd0);
    reset_n         = 1'b1;
    bus4.out_ready  = 1'b1;
    bus32.out_ready = 1'b1;

    syn_code = 8'h8A; #1;
    check("syn_8a", 64'({syn_s, syn_p}), 64'({3'd5, 1'b1}));
    syn_code = 8'hAC; #1;
    check("syn_ac", 64'({syn_s, syn_p}), 64'({3'd3, 1'b0}));
    syn_code = 8'hAB; #1;
    check("syn_ab", 64'({syn_s, syn_p}), 64'({3'd0, 1'b1}));
    syn_code = 8'hAA; #1;
    check("syn_aa", 64'({syn_s, syn_p}), 64'({3'd0, 1'b0}));

    @(posedge clk);
    #1;
    send(0, 64'hAA, '{data: 64'hB, single: 1'b0, dbl: 1'b0});
    @(negedge clk);
    check("lat_edge1", 64'(bus4.out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(bus4.out_valid), 64'd1);
    @(posedge clk);
    #1;
    send(0, 64'h8A, '{data: 64'hB, single: 1'b1, dbl: 1'b0});
    wait_drain(0);
    check("cnt_single_1", 64'(cs4), 64'd1);
    send(0, 64'hAB, '{data: 64'hB, single: 1'b1, dbl: 1'b0});
    send(0, 64'hAC, '{data: 64'hB, single: 1'b0, dbl: 1'b1});
    wait_drain(0);
    check("cnt_single_2", 64'(cs4), 64'd2);
    check("cnt_double_1", 64'(cd4), 64'd1);

    fork
      begin
        for (int unsigned i = 0; i < 16; i++) begin
          d  = 64'($urandom_range(0, 15));
          nf = $urandom_range(0, 2);
          p1 = $urandom_range(0, 7);
          p2 = (p1 + 1 + $urandom_range(0, 6)) % 8;
          c  = m_encode(4, d);
          if (nf >= 1) c[p1] = ~c[p1];
          if (nf == 2) c[p2] = ~c[p2];
          send(0, c, m_expect(4, d, c, nf));
        end
        wait_drain(0);
        done = 1'b1;
      end
      begin
        int unsigned ph;
        ph = 0;
        while (!done) begin
          bus4.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
          @(posedge clk);
          #1;
        end
        bus4.out_ready = 1'b1;
      end
    join

    clr4 = 1'b1;
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    check("clr_single4", 64'(cs4), 64'd0);
    check("clr_double4", 64'(cd4), 64'd0);

    for (int unsigned i = 0; i < 5; i++) begin
      d  = 64'($urandom_range(0, 15));
      c  = m_encode(4, d);
      p1 = $urandom_range(0, 7);
      c[p1] = ~c[p1];
      send(0, c, m_expect(4, d, c, 1));
    end
    wait_drain(0);
    check("sat_single4", 64'(cs4), 64'd3);
    check("sat_double4", 64'(cd4), 64'd0);
    c = 64'h8A;
    send(0, c, '{data: 64'hB, single: 1'b1, dbl: 1'b0});
    @(posedge clk);
    #1;
    clr4 = 1'b1;
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    check("clr_prio4", 64'(cs4), 64'd0);

    d    = 64'($urandom);
    base = m_encode(32, d);
    send(1, base, m_expect(32, d, base, 0));
    for (int unsigned a = 0; a < 39; a++) begin
      c = base ^ (64'd1 << a);
      send(1, c, m_expect(32, d, c, 1));
    end
    for (int unsigned a = 0; a < 39; a++) begin
      for (int unsigned b = a + 1; b < 39; b++) begin
        c = base ^ (64'd1 << a) ^ (64'd1 << b);
        send(1, c, m_expect(32, d, c, 2));
      end
    end
    // Three flips whose syndrome 32^4^3 = 39 lands just past the codeword.
    c = base ^ (64'd1 << 32) ^ (64'd1 << 4) ^ (64'd1 << 3);
    send(1, c, '{data: m_extract(32, c), single: 1'b0, dbl: 1'b1});
    wait_drain(1);
    check("cnt_single32", 64'(cs32), 64'd39);
    check("cnt_double32", 64'(cd32), 64'd742);

    c = base ^ (64'd1 << 5);
    send(1, c, m_expect(32, d, c, 1));
    @(posedge clk);
    #1;
    clr32 = 1'b1;
    @(posedge clk);
    #1;
    clr32 = 1'b0;
    check("clr_prio32", 64'({cs32, cd32}), 64'd0);

    bus32.out_ready = 1'b0;
    send(1, base, m_expect(32, d, base, 0));
    c = base ^ 64'd1;
    send(1, c, m_expect(32, d, c, 1));
    @(posedge clk);
    #1;
    check("full_ready32", 64'(bus32.in_ready), 64'd0);
    #1;
    reset_n = 1'b0;
    q32.delete();
    q4.delete();
    #1;
    check("midrst_valid32", 64'(bus32.out_valid), 64'd0);
    check("midrst_data32", 64'(bus32.out_data), 64'd0);
    check("midrst_ready32", 64'(bus32.in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus32.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_valid32", 64'(bus32.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
